// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the lab ALU datapath.
//   state_t  - sequencer states of the multi-cycle adder (IDLE, RUN, DONE)
//   GROUP_W  - bits resolved per lookahead group (one group per clock)
package alu_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_unit.sv
// cla4_unit: combinational 4-bit carry-lookahead unit.
//   g[3:0], p[3:0] : per-bit generate / propagate
//   c0             : carry into bit 0 of the group
//   c[4:1]         : carries into bits 1..3 and out of bit 3
//   g_grp, p_grp   : group generate / propagate (c[4] = g_grp | p_grp & c0)
module cla4_unit
    import alu_pkg::*;
(
    input  logic [GROUP_W-1:0] g,
    input  logic [GROUP_W-1:0] p,
    input  logic               c0,
    output logic [GROUP_W:1]   c,
    output logic               g_grp,
    output logic               p_grp
);

    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0);
    assign c[4] = g_grp | (p_grp & c0);

    assign g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign p_grp = &p;

endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle WIDTH-bit adder resolving one 4-bit lookahead
// group per clock under a start/done handshake.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start           : request, accepted only in IDLE
//   x, y, cin       : operands and carry-in, captured on accepted start
//   sub             : subtract select (only when ALU_SUB_EN is defined)
//   busy            : high while groups are being resolved
//   done            : one-cycle completion pulse
//   f, cout, ovf, zf: result and flags, updated only on completion
// Build option: define ALU_SUB_EN to add the sub port (x - y as x + ~y + 1).
module cla_seq_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
`ifdef ALU_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             ovf,
    output logic             zf
);

    localparam int N  = WIDTH / GROUP_W;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_x, r_y, r_work, r_f;
    logic               r_carry, r_busy, r_done, r_cout, r_ovf, r_zf;
    logic [KW-1:0]      r_k;

    logic [GROUP_W-1:0] w_xg, w_yg, w_g, w_p, w_sum;
    logic [GROUP_W:1]   w_c;
    logic               w_gg, w_pg, w_c_out, w_last;
    logic [WIDTH-1:0]   w_work_nxt;

    // Select the operand slice of the current group.
    always_comb begin
        w_xg = '0;
        w_yg = '0;
        for (int j = 0; j < N; j++) begin
            if (r_k == KW'(j)) begin
                w_xg = r_x[j*GROUP_W +: GROUP_W];
                w_yg = r_y[j*GROUP_W +: GROUP_W];
            end
        end
    end

    assign w_g = w_xg & w_yg;
    assign w_p = w_xg | w_yg;

    cla4_unit u_cla4 (
        .g     (w_g),
        .p     (w_p),
        .c0    (r_carry),
        .c     (w_c),
        .g_grp (w_gg),
        .p_grp (w_pg)
    );

    assign w_sum   = w_xg ^ w_yg ^ {w_c[3:1], r_carry};
    assign w_c_out = w_gg | (w_pg & r_carry);
    assign w_last  = (r_k == KW'(N - 1));

    // Working register with the current group's sum merged in; on the last
    // group this is the full result, so f/zf are taken from it directly.
    always_comb begin
        w_work_nxt = r_work;
        for (int j = 0; j < N; j++) begin
            if (r_k == KW'(j))
                w_work_nxt[j*GROUP_W +: GROUP_W] = w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_f     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x     <= x;
                        r_k     <= '0;
                        r_work  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
`ifdef ALU_SUB_EN
                        r_y     <= sub ? ~y : y;
                        r_carry <= sub | cin;
`else
                        r_y     <= y;
                        r_carry <= cin;
`endif
                    end
                end
                RUN: begin
                    r_work  <= w_work_nxt;
                    r_carry <= w_c_out;
                    r_k     <= r_k + KW'(1);
                    if (w_last) begin
                        r_f     <= w_work_nxt;
                        r_cout  <= w_c_out;
                        r_ovf   <= w_c[3] ^ w_c[4];
                        r_zf    <= (w_work_nxt == '0);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign f    = r_f;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zf   = r_zf;

endmodule

// File: tb/tb_cla_seq_adder.sv
module tb_cla_seq_adder;

    localparam int W = 32;
    localparam int N = W / 4;

    logic         clk, rst, start, cin, sub;
    logic [W-1:0] x, y;
    logic         busy, done, cout, ovf, zf;
    logic [W-1:0] f;

    int n_vec = 0;
    int n_err = 0;

    // expected values of the held result outputs
    logic [W-1:0] e_f;
    logic         e_c, e_v, e_z;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .cin   (cin),
`ifdef ALU_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .f     (f),
        .cout  (cout),
        .ovf   (ovf),
        .zf    (zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modulo-2^W arithmetic on the effective operands.
    task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sb);
        logic [W-1:0] yy;
        logic         cc;
        logic [W:0]   s;
        yy  = sb ? ~b : b;
        cc  = sb ? 1'b1 : ci;
        s   = {1'b0, a} + {1'b0, yy} + {{W{1'b0}}, cc};
        e_f = s[W-1:0];
        e_c = s[W];
        e_v = (a[W-1] == yy[W-1]) && (e_f[W-1] != a[W-1]);
        e_z = (e_f == '0);
    endtask

    // Full operation from accepted start (cycle 0) through cycle N+2.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb);
        logic [W-1:0] pf;
        logic         pc, pv, pz, bad;
`ifndef ALU_SUB_EN
        sb = 1'b0;
`endif
        pf = e_f; pc = e_c; pv = e_v; pz = e_z;
        model_op(a, b, ci, sb);
        x = a; y = b; cin = ci; sub = sb; start = 1'b1;
        tick;
        start = 1'b0;
        x = $urandom; y = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        bad = 1'b0;
        for (int c = 1; c <= N; c++) begin
            if (busy !== 1'b1 || done !== 1'b0 || f !== pf || cout !== pc ||
                ovf !== pv || zf !== pz) bad = 1'b1;
            tick;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL run_phase a=%h b=%h: busy/done wrong or outputs changed mid-op", a, b);
        end
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_cycle a=%h b=%h: done=%b busy=%b, required done=1 busy=0", a, b, done, busy);
        end
        n_vec++;
        if (f !== e_f || cout !== e_c || ovf !== e_v || zf !== e_z) begin
            n_err++;
            $display("FAIL result a=%h b=%h cin=%b sub=%b: got f=%h c=%b v=%b z=%b, required f=%h c=%b v=%b z=%b",
                     a, b, ci, sb, f, cout, ovf, zf, e_f, e_c, e_v, e_z);
        end
        tick;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse a=%h b=%h: done=%b busy=%b one cycle later, required 0 0", a, b, done, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        tick; tick;
        rst = 1'b0;
        e_f = '0; e_c = 1'b0; e_v = 1'b0; e_z = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || f !== '0 || cout !== 1'b0 ||
            ovf !== 1'b0 || zf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b f=%h c=%b v=%b z=%b, required all 0",
                     busy, done, f, cout, ovf, zf);
        end
    endtask

    task automatic test_directed;
        run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        n_vec++;
        if (f !== 32'h0 || cout !== 1'b1 || ovf !== 1'b0 || zf !== 1'b1) begin
            n_err++;
            $display("FAIL plan_wrap_zero: f=%h c=%b v=%b z=%b, required 00000000 1 0 1", f, cout, ovf, zf);
        end
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        n_vec++;
        if (f !== 32'h8000_0000 || cout !== 1'b0 || ovf !== 1'b1 || zf !== 1'b0) begin
            n_err++;
            $display("FAIL plan_ovf: f=%h c=%b v=%b z=%b, required 80000000 0 1 0", f, cout, ovf, zf);
        end
        run_op(32'h0000_000F, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (f !== 32'h0000_0010 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL plan_group_carry: f=%h c=%b, required 00000010 0", f, cout);
        end
        run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (f !== 32'h0 || cout !== 1'b1 || zf !== 1'b1) begin
            n_err++;
            $display("FAIL cin_ripple_all: f=%h c=%b z=%b, required 00000000 1 1", f, cout, zf);
        end
`ifdef ALU_SUB_EN
        run_op(32'd5, 32'd7, 1'b0, 1'b1);
        n_vec++;
        if (f !== 32'hFFFF_FFFE || cout !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL plan_sub_neg: f=%h c=%b v=%b, required FFFFFFFE 0 0", f, cout, ovf);
        end
        run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        n_vec++;
        if (f !== 32'h7FFF_FFFF || cout !== 1'b1 || ovf !== 1'b1) begin
            n_err++;
            $display("FAIL plan_sub_ovf: f=%h c=%b v=%b, required 7FFFFFFF 1 1", f, cout, ovf);
        end
`endif
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic [W-1:0] pick [4];
        pick[0] = 32'h0; pick[1] = 32'hFFFF_FFFF;
        pick[2] = 32'h8000_0000; pick[3] = 32'h7FFF_FFFF;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : W'($urandom);
            run_op(a, b, 1'($urandom), 1'($urandom));
        end
    endtask

    // Extra start requests in RUN (cycle 3) and DONE (cycle 9) must be dropped.
    task automatic test_ignored_start;
        logic [W-1:0] a, b;
        a = $urandom; b = $urandom;
        model_op(a, b, 1'b0, 1'b0);
        x = a; y = b; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= N + 1; c++) begin
            if (c == 3) begin
                start = 1'b1; x = $urandom; y = $urandom;
            end else if (c == 4) begin
                start = 1'b0;
            end
            if (c == N + 1) begin
                n_vec++;
                if (done !== 1'b1 || f !== e_f || cout !== e_c || ovf !== e_v || zf !== e_z) begin
                    n_err++;
                    $display("FAIL ignored_start_result: done=%b f=%h, required done=1 f=%h", done, f, e_f);
                end
                start = 1'b1;
            end
            tick;
        end
        start = 1'b0;
        tick;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL ignored_start_queued: busy=%b done=%b after op, required 0 0", busy, done);
        end
    endtask

    // Reset in cycle 4 of an operation discards it and clears the outputs.
    task automatic test_reset_abort;
        logic bad;
        x = $urandom | 32'h1; y = $urandom; cin = 1'b1; sub = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        e_f = '0; e_c = 1'b0; e_v = 1'b0; e_z = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || f !== '0 || cout !== 1'b0 ||
            ovf !== 1'b0 || zf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort: busy=%b done=%b f=%h c=%b v=%b z=%b, required all 0",
                     busy, done, f, cout, ovf, zf);
        end
        bad = 1'b0;
        for (int c = 0; c < N + 4; c++) begin
            tick;
            if (done !== 1'b0 || busy !== 1'b0 || f !== '0) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL reset_abort_tail: done/busy/f became nonzero after aborted op");
        end
    endtask

    // start held high: completions every N+2 cycles (9, 19, 29 for W=32).
    task automatic test_back_to_back;
        logic [W-1:0] a, b;
        int hits[$];
        a = $urandom; b = $urandom;
        model_op(a, b, 1'b1, 1'b0);
        x = a; y = b; cin = 1'b1; sub = 1'b0; start = 1'b1;
        for (int c = 1; c <= 3 * (N + 2); c++) begin
            tick;
            if (c == 3 * (N + 2)) start = 1'b0;
            if (done === 1'b1) hits.push_back(c);
        end
        n_vec++;
        if (hits.size() != 3 || hits[0] != N + 1 || hits[1] != 2 * N + 3 || hits[2] != 3 * N + 5) begin
            n_err++;
            $display("FAIL back_to_back_timing: %0d done pulses, first at %0d, required 3 at %0d/%0d/%0d",
                     hits.size(), (hits.size() > 0) ? hits[0] : -1, N + 1, 2 * N + 3, 3 * N + 5);
        end
        n_vec++;
        if (f !== e_f || cout !== e_c || ovf !== e_v || zf !== e_z) begin
            n_err++;
            $display("FAIL back_to_back_result: f=%h c=%b, required f=%h c=%b", f, cout, e_f, e_c);
        end
        tick;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_back_stop: busy=%b after start dropped, required 0", busy);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignored_start;
        test_reset_abort;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
